// File: rtl/vdp_command_pkg.sv
// vdp_command_pkg: screen modes, line widths and byte-mapping helpers shared by the byte-mode command executors
package vdp_command_pkg;
  localparam logic [1:0] SCR5 = 2'd0;
  localparam logic [1:0] SCR6 = 2'd1;
  localparam logic [1:0] SCR7 = 2'd2;
  localparam logic [1:0] SCR8 = 2'd3;
  localparam int LINE_NARROW = 128;
  localparam int LINE_WIDE = 256;
  localparam logic [9:0] NX_MAX = 10'd512;
  localparam logic [10:0] NY_MAX = 11'd1024;
  typedef enum logic [1:0] {HMMV_IDLE, HMMV_WRITE, HMMV_DONE} hmmv_state_e;
  function automatic logic [1:0] byte_shift(input logic [1:0] mode);
    return (mode == SCR5 || mode == SCR7) ? 2'd1 : mode == SCR6 ? 2'd2 : 2'd0;
  endfunction
  function automatic logic wide_line(input logic [1:0] mode);
    return mode == SCR7 || mode == SCR8;
  endfunction
  function automatic logic [7:0] line_mask(input logic [1:0] mode);
    return wide_line(mode) ? 8'(LINE_WIDE - 1) : 8'(LINE_NARROW - 1);
  endfunction
endpackage

// File: rtl/vdp_command_xy_to_addr.sv
// vdp_command_xy_to_addr: maps a bitmap byte position (dy, xb) to a linear VRAM byte address
module vdp_command_xy_to_addr #(
  parameter int VRAM_AW = 18
) (
  input  logic [1:0]         screen_mode,
  input  logic [9:0]         dy,
  input  logic [7:0]         xb,
  output logic [VRAM_AW-1:0] vram_addr
);
  import vdp_command_pkg::*;
  always_comb vram_addr = wide_line(screen_mode) ? VRAM_AW'({dy, xb}) : VRAM_AW'({dy, xb[6:0]});
endmodule

// File: rtl/vdp_command_hmmv.sv
// vdp_command_hmmv: HMMV byte fill, walks the DX/DY/NX/NY rectangle issuing one VRAM write per byte
module vdp_command_hmmv #(
  parameter int VRAM_AW = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         screen_mode,
  input  logic [8:0]         reg_dx,
  input  logic [9:0]         reg_dy,
  input  logic [8:0]         reg_nx,
  input  logic [9:0]         reg_ny,
  input  logic [7:0]         reg_col,
  input  logic               reg_dix,
  input  logic               reg_diy,
  output logic               busy,
  output logic               done,
  output logic               vram_req,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_ack,
  output logic [9:0]         result_dy,
  output logic [9:0]         result_ny
);
  import vdp_command_pkg::*;
  hmmv_state_e state;
  logic [1:0] mode, sh;
  logic [7:0] x, x0, col, x_start;
  logic [9:0] dy, nxb, cnt, nx_eff, nx_s, nxb_start, dy_step;
  logic [10:0] ny;
  logic dix, diy, edge_hit, row_end;
  always_comb begin
    sh = byte_shift(screen_mode);
    x_start = 8'(reg_dx >> sh) & line_mask(screen_mode);
    nx_eff = reg_nx == '0 ? NX_MAX : {1'b0, reg_nx};
    nx_s = nx_eff >> sh;
    nxb_start = nx_s == '0 ? 10'd1 : nx_s;
    edge_hit = dix ? x == 8'd0 : x == line_mask(mode);
    row_end = cnt == 10'd1 || edge_hit;
    dy_step = diy ? dy - 10'd1 : dy + 10'd1;
  end
  assign busy = state == HMMV_WRITE;
  assign vram_req = state == HMMV_WRITE;
  assign done = state == HMMV_DONE;
  assign vram_wdata = col;
  vdp_command_xy_to_addr #(.VRAM_AW(VRAM_AW)) u_addr (
    .screen_mode(mode),
    .dy(dy),
    .xb(x),
    .vram_addr(vram_addr)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HMMV_IDLE;
      mode <= '0;
      x <= '0;
      x0 <= '0;
      col <= '0;
      dy <= '0;
      nxb <= '0;
      cnt <= '0;
      ny <= '0;
      dix <= 1'b0;
      diy <= 1'b0;
      result_dy <= '0;
      result_ny <= '0;
    end else begin
      case (state)
        HMMV_IDLE: if (start && !abort) begin
          state <= HMMV_WRITE;
          mode <= screen_mode;
          x <= x_start;
          x0 <= x_start;
          col <= reg_col;
          dy <= reg_dy;
          nxb <= nxb_start;
          cnt <= nxb_start;
          ny <= reg_ny == '0 ? NY_MAX : {1'b0, reg_ny};
          dix <= reg_dix;
          diy <= reg_diy;
        end
        HMMV_WRITE: begin
          if (vram_ack && row_end) begin
            x <= x0;
            cnt <= nxb;
            dy <= dy_step;
            ny <= ny - 11'd1;
            result_dy <= dy_step;
            result_ny <= 10'(ny - 11'd1);
            if (ny == 11'd1) state <= HMMV_DONE;
          end else if (vram_ack) begin
            x <= dix ? x - 8'd1 : x + 8'd1;
            cnt <= cnt - 10'd1;
          end
          // an ack in the abort cycle still counts, so only fall back to the live position without a row end
          if (abort) begin
            state <= HMMV_IDLE;
            if (!(vram_ack && row_end)) begin
              result_dy <= dy;
              result_ny <= ny[9:0];
            end
          end
        end
        default: state <= HMMV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vdp_command_hmmv.sv
// tb_vdp_command_hmmv: directed and random HMMV fills checked against a rectangle-walk reference model
module tb_vdp_command_hmmv;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, reg_dix = 1'b0, reg_diy = 1'b0, vram_ack = 1'b0;
  logic [1:0] screen_mode = '0;
  logic [8:0] reg_dx = '0, reg_nx = '0;
  logic [9:0] reg_dy = '0, reg_ny = '0;
  logic [7:0] reg_col = '0;
  logic busy, done, vram_req;
  logic [17:0] vram_addr;
  logic [7:0] vram_wdata;
  logic [9:0] result_dy, result_ny;
  int total = 0, bad = 0;
  int exp_addr[$], exp_rdy[$], exp_rny[$];
  always #5 clk = ~clk;
  vdp_command_hmmv #(.VRAM_AW(18)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .screen_mode(screen_mode),
    .reg_dx(reg_dx), .reg_dy(reg_dy), .reg_nx(reg_nx), .reg_ny(reg_ny), .reg_col(reg_col),
    .reg_dix(reg_dix), .reg_diy(reg_diy), .busy(busy), .done(done), .vram_req(vram_req),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
    .result_dy(result_dy), .result_ny(result_ny)
  );
  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_req"}, vram_req, 0);
    check({tag, "_addr"}, vram_addr, 0);
    check({tag, "_wdata"}, vram_wdata, 0);
    check({tag, "_rdy"}, result_dy, 0);
    check({tag, "_rny"}, result_ny, 0);
  endtask
  // expected write sequence plus the dy / remaining rows the block should report after each write
  task automatic build(input int mode, dx, dy, nx, ny, dix, diy, max_n);
    int sh, w, xb0, nxb, rows, y, x;
    bit last;
    exp_addr.delete();
    exp_rdy.delete();
    exp_rny.delete();
    sh = (mode == 1) ? 2 : (mode == 3) ? 0 : 1;
    w = (mode >= 2) ? 256 : 128;
    xb0 = (dx >> sh) % w;
    nxb = ((nx == 0) ? 512 : nx) >> sh;
    if (nxb == 0) nxb = 1;
    rows = (ny == 0) ? 1024 : ny;
    y = dy;
    for (int r = 0; r < rows && exp_addr.size() < max_n; r++) begin
      x = xb0;
      for (int k = 0; k < nxb; k++) begin
        last = (k == nxb - 1) || (dix != 0 ? x == 0 : x == w - 1);
        exp_addr.push_back(y * w + x);
        exp_rdy.push_back(last ? (y + (diy != 0 ? 1023 : 1)) % 1024 : y);
        exp_rny.push_back(last ? (rows - r - 1) % 1024 : (rows - r) % 1024);
        if (last) break;
        x += (dix != 0) ? -1 : 1;
      end
      y = (y + (diy != 0 ? 1023 : 1)) % 1024;
    end
  endtask
  task automatic run(input string name, input int mode, dx, dy, nx, ny, col, dix, diy,
                     input bit rnd_ack, input bit poke, input int abort_at, input int reset_at);
    int n, nexp, cyc, prev_addr, prev_data;
    bit stall, fin;
    build(mode, dx, dy, nx, ny, dix, diy, (abort_at > 0) ? abort_at + 4 : (reset_at > 0) ? reset_at + 4 : 1 << 30);
    nexp = exp_addr.size();
    @(negedge clk);
    screen_mode = 2'(mode); reg_dx = 9'(dx); reg_dy = 10'(dy); reg_nx = 9'(nx); reg_ny = 10'(ny);
    reg_col = 8'(col); reg_dix = dix[0]; reg_diy = diy[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    screen_mode = 2'($urandom); reg_dx = 9'($urandom); reg_dy = 10'($urandom); reg_nx = 9'($urandom);
    reg_ny = 10'($urandom); reg_col = 8'($urandom); reg_dix = 1'($urandom); reg_diy = 1'($urandom);
    check({name, "_lat_busy"}, busy, 1);
    check({name, "_lat_req"}, vram_req, 1);
    n = 0; cyc = 0; stall = 1'b0; fin = 1'b0; prev_addr = 0; prev_data = 0;
    while (!fin && cyc < 20000) begin
      if (stall) begin
        check({name, "_hold_req"}, vram_req, 1);
        check({name, "_hold_addr"}, vram_addr, prev_addr);
        check({name, "_hold_data"}, vram_wdata, prev_data);
      end
      if (done) begin
        check({name, "_done_busy"}, busy, 0);
        check({name, "_done_req"}, vram_req, 0);
        check({name, "_count"}, n, nexp);
        check({name, "_rdy"}, result_dy, exp_rdy[nexp-1]);
        check({name, "_rny"}, result_ny, exp_rny[nexp-1]);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_idle_req"}, vram_req, 0);
        fin = 1'b1;
      end else begin
        vram_ack = rnd_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
        start = poke && busy && $urandom_range(0, 2) == 0;
        if (vram_req && vram_ack) begin
          if (n >= nexp) check({name, "_extra"}, n, nexp - 1);
          else begin
            check({name, "_addr"}, vram_addr, exp_addr[n]);
            check({name, "_data"}, vram_wdata, col);
          end
          n++;
          if (n == abort_at) abort = 1'b1;
          if (n == reset_at) reset = 1'b1;
        end
        stall = vram_req && !vram_ack;
        prev_addr = vram_addr;
        prev_data = vram_wdata;
        @(negedge clk);
        start = 1'b0;
        vram_ack = 1'b0;
        if (abort) begin
          abort = 1'b0;
          check({name, "_ab_busy"}, busy, 0);
          check({name, "_ab_req"}, vram_req, 0);
          check({name, "_ab_done"}, done, 0);
          check({name, "_ab_rdy"}, result_dy, exp_rdy[n-1]);
          check({name, "_ab_rny"}, result_ny, exp_rny[n-1]);
          repeat (3) begin
            @(negedge clk);
            check({name, "_ab_quiet"}, {30'd0, vram_req, done}, 0);
          end
          fin = 1'b1;
        end
        if (reset) begin
          reset = 1'b0;
          check_zero({name, "_rst"});
          repeat (3) begin
            @(negedge clk);
            check({name, "_rst_quiet"}, {30'd0, vram_req, busy}, 0);
          end
          fin = 1'b1;
        end
        cyc++;
      end
    end
    if (!fin) check({name, "_timeout"}, 0, 1);
  endtask
  initial begin
    int rdy, rny;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    run("t1", 2, 0, 0, 0, 2, 'h44, 0, 0, 0, 0, 0, 0);
    check("t1_final_dy", result_dy, 2);
    check("t1_final_ny", result_ny, 0);
    run("t2", 0, 250, 5, 20, 1, 'h5a, 0, 0, 0, 0, 0, 0);
    run("t3", 3, 3, 0, 8, 2, 'hc3, 1, 1, 0, 0, 0, 0);
    check("t3_final_dy", result_dy, 1022);
    run("t4", 1, 8, 0, 16, 1, 'h81, 0, 0, 1, 1, 0, 0);
    run("t5", 2, 0, 0, 0, 848, 'h0f, 0, 0, 0, 0, 300, 0);
    check("t5_final_dy", result_dy, 1);
    check("t5_final_ny", result_ny, 847);
    rdy = result_dy;
    rny = result_ny;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_wins_busy", busy, 0);
    check("abort_wins_req", vram_req, 0);
    check("idle_stable_dy", result_dy, rdy);
    check("idle_stable_ny", result_ny, rny);
    run("t6", 2, 0, 0, 0, 2, 'h44, 0, 0, 0, 0, 0, 100);
    run("t6b", 2, 0, 0, 0, 2, 'h44, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      run("rnd", $urandom_range(0, 3), $urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 511),
          $urandom_range(1, 3), $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 1'b1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vdp_command_hmmv.md
Name: vdp_command_hmmv

Overview:
HMMV (high-speed byte fill) executor of the VDP command engine, used for SCREEN5–8 bitmap modes. It accepts latched command registers R#36–R#46 from the register file and walks the DX/DY/NX/NY rectangle byte by byte. For each byte it issues a write request carrying COL to the VRAM access arbiter, which feeds the SDRAM controller. It also reports the CE status and the updated DY/NY values back to the register file.

Parameters:
VRAM_AW, 18, VRAM byte address width (256 KB logical VRAM)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: CMD=HMMV written to R#46
abort  in  1  one-cycle pulse: STOP command written
screen_mode  in  2  0=SCREEN5, 1=SCREEN6, 2=SCREEN7, 3=SCREEN8
reg_dx  in  9  DX (pixel units)
reg_dy  in  10  DY
reg_nx  in  9  NX (pixel units, 0 = 512)
reg_ny  in  10  NY (0 = 1024)
reg_col  in  8  fill byte
reg_dix  in  1  0 = +X, 1 = -X
reg_diy  in  1  0 = +Y, 1 = -Y
busy  out  1  CE status bit
done  out  1  one-cycle completion pulse
vram_req  out  1  write request
vram_addr  out  VRAM_AW  byte address
vram_wdata  out  8  write data
vram_ack  in  1  arbiter accepts the request this cycle
result_dy  out  10  DY after execution (written back to R#38/39)
result_ny  out  10  NY after execution (written back to R#42/43)

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high. On reset: state=IDLE; busy, done, vram_req = 0; vram_addr, vram_wdata, result_dy, result_ny = 0. Reset mid-operation abandons the command immediately; no further requests are issued.
- Byte mapping:
  - shift = 1 for SCREEN5/7, 2 for SCREEN6, 0 for SCREEN8.
  - Line width W = 128 bytes (SCREEN5/6) or 256 bytes (SCREEN7/8).
  - Byte X start xb = (reg_dx >> shift) masked to W-1.
  - NX byte count: nxb = (NX_eff >> shift), where NX_eff = 512 if reg_nx == 0, otherwise reg_nx. If nxb == 0, use 1.
- Address:
  - SCREEN5/6: {dy[9:0], xb[6:0]}, zero-extended to VRAM_AW.
  - SCREEN7/8: {dy[9:0], xb[7:0]}.
- Edge clamp: a row ends when its byte count is exhausted, or after writing the edge byte (xb = W-1 for +X, xb = 0 for -X). X never wraps.
- Y stepping: after each row, dy = dy ± 1 modulo 1024 and the remaining-row count is decremented. The row count starts at 1024 when reg_ny == 0.
- FSM:
  - IDLE: when start=1 and abort=0, latch all registers and screen_mode → WRITE.
  - WRITE: vram_req=1, vram_wdata=col.
    - On vram_ack: advance X, or advance to the next row.
    - If the last byte of the last row was acked → DONE.
    - abort → IDLE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Latency: start sampled at cycle T → busy=1 and vram_req=1 with the first address at T+1.
- Throughput: up to 1 byte per clock. When ack is high and more bytes remain, req stays high and the next address appears in the following cycle.
- Handshake: while req=1 and ack=0, addr and wdata hold stable. req never drops without an ack, except on abort or reset.
- busy: 1 from T+1 until the cycle DONE is entered; busy is low in the DONE cycle.
- start while busy: ignored. Register inputs are don't-care after latching.
- abort while busy:
  - Next cycle: req=0, busy=0, no done pulse.
  - An ack sampled in the same cycle as abort counts as a completed write.
  - The arbiter tolerates a withdrawn request.
- abort while in IDLE is ignored; abort wins over a simultaneous start.
- result_dy / result_ny: updated at every row end (and on abort) to the current dy and remaining row count modulo 1024. Stable while IDLE.

Decomposition:
- Package vdp_command_pkg: screen_mode encoding constants, hmmv state enum, line-width constants (128/256), NX/NY zero-means-max constants.
- One combinational sub-module, vdp_command_xy_to_addr (screen_mode, dy, xb → vram_addr). It will be reused by the other byte-mode commands.

Test Plan:
1. SCREEN7, DX=0, DY=0, NX=0, NY=2, COL=0x44, ack tied 1 → exactly 512 requests at addresses 0x00000..0x001FF, all data 0x44; a single done pulse; result_dy=2, result_ny=0.
2. SCREEN5, DX=250, DY=5, NX=20, NY=1 → edge clamp: 3 writes at 0x002FD, 0x002FE, 0x002FF; then done.
3. SCREEN8, DIX=1, DIY=1, DX=3, DY=0, NX=8, NY=2 → writes 0x00003..0x00000, then 0x3FF03..0x3FF00; result_dy=1022.
4. SCREEN6, DX=8, NX=16, NY=1 with random ack stalls → 4 writes at 0x002..0x005; addr and data held stable during every stall; start pulses during busy ignored.
5. SCREEN7 full fill (NX=0, NY=848) → abort after 300 acks: busy=0 and no req from the next cycle, no done pulse, result_dy=1, result_ny=847.
6. Reset asserted mid-row during test 1 → next cycle all outputs 0 and state IDLE; a subsequent start runs test 1 cleanly.
